piso_rt_serializer: RTL and testbench

- Parallel-in, serial-out transmitter. LSB is shifted out first, so a right-shift SIPO receiver fed from s_out reassembles the original word on its parallel output.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per enabled cycle.
- Marks frame activity and the last bit of each frame.
- Sits on the transmit side of the serial link, paired with the SIPO receiver in the same design.

---
 rtl/piso_pkg.sv | 17 +
 rtl/piso_rt_serializer.sv | 109 ++++++++++
 tb/tb_piso_rt_serializer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter.
// Holds the frame state encoding and the bit-counter width helper.
package piso_pkg;

    // Frame state: waiting for a word, or emitting one bit per enabled cycle.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_e;

    // Width of a counter that indexes bit positions 0..width-1.
    // Callers keep width >= 2, so the result is always at least one bit.
    function automatic int piso_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage : piso_pkg

// File: rtl/piso_rt_serializer.sv
// Parallel-in, serial-out transmitter, LSB first.
// A word is taken through a valid/ready handshake and emitted one bit per
// shift_en cycle. On the final bit with shift_en high a new word may be
// accepted in the same cycle, giving gap-free back-to-back frames.
// Serial outputs decode registered state only; load_ready is the single
// output that also looks at an input (shift_en).
module piso_rt_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] p_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    localparam int CNT_W = piso_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    piso_state_e      state_r;
    piso_state_e      state_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] bit_cnt_nxt_s;
    logic             load_ready_s;
    logic             at_last_s;

    assign at_last_s = (state_r == ST_SHIFT) && (bit_cnt_r == CNT_LAST);

    // Next-state, shift-register and counter decode, plus the ready handshake.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bit_cnt_nxt_s = bit_cnt_r;
        load_ready_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // shift_en has no meaning until a word is held.
                load_ready_s = 1'b1;
                if (load_valid) begin
                    shift_nxt_s   = p_in;
                    bit_cnt_nxt_s = CNT_ZERO;
                    state_nxt_s   = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (bit_cnt_r == CNT_LAST) begin
                        // Final bit leaves on this edge: a waiting word can
                        // follow directly without an idle cycle.
                        load_ready_s = 1'b1;
                        if (load_valid) begin
                            shift_nxt_s   = p_in;
                            bit_cnt_nxt_s = CNT_ZERO;
                            state_nxt_s   = ST_SHIFT;
                        end else begin
                            shift_nxt_s   = {WIDTH{1'b0}};
                            bit_cnt_nxt_s = CNT_ZERO;
                            state_nxt_s   = ST_IDLE;
                        end
                    end else begin
                        shift_nxt_s   = {1'b0, shift_r[WIDTH-1:1]};
                        bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                    end
                end else begin
                    // Bit-rate enable low: hold the current bit on the line.
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                shift_nxt_s   = {WIDTH{1'b0}};
                bit_cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // State, shift register and bit counter; reset abandons any frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= CNT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            shift_r   <= shift_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
        end
    end

    assign load_ready = load_ready_s;
    assign s_valid    = (state_r == ST_SHIFT);
    assign busy       = (state_r == ST_SHIFT);
    assign s_out      = (state_r == ST_SHIFT) && shift_r[0];
    assign s_last     = at_last_s;

endmodule : piso_rt_serializer

// File: tb/tb_piso_rt_serializer.sv
// Self-checking bench for piso_rt_serializer (WIDTH=4).
// A word-level model (word + index of the bit on the line) predicts every
// output each cycle; a SIPO built in the bench reassembles frames and checks
// them against the queue of words the model saw accepted.
module tb_piso_rt_serializer;

    localparam int W = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] p_in;
    logic         load_valid;
    logic         load_ready;
    logic         shift_en;
    logic         s_out;
    logic         s_valid;
    logic         s_last;
    logic         busy;

    piso_rt_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .p_in       (p_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .s_out      (s_out),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .busy       (busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: is a frame on the line, which word, which bit.
    logic         m_active;
    logic [W-1:0] m_word;
    int           m_idx;
    logic [W-1:0] exp_q[$];   // accepted words awaiting reassembly
    logic [W-1:0] src_q[$];   // words the source still has to offer
    logic [W-1:0] sipo;
    int           nbits;
    logic         bit_log[$]; // bits seen on enabled edges
    logic [W-1:0] rx_log[$];  // words reassembled by the bench SIPO
    int           vcnt;       // cycles with s_valid high

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        m_word   = '0;
        m_idx    = 0;
        exp_q.delete();
        sipo     = '0;
        nbits    = 0;
    endtask

    // Compare every output against the model (called once per cycle).
    task automatic check_outputs();
        logic e_out, e_last, e_ready;
        e_out   = m_active ? m_word[m_idx] : 1'b0;
        e_last  = m_active && (m_idx == W - 1);
        e_ready = !m_active || ((m_idx == W - 1) && shift_en);
        chk("s_out", 32'(s_out), 32'(e_out));
        chk("s_valid", 32'(s_valid), 32'(m_active));
        chk("busy", 32'(busy), 32'(m_active));
        chk("s_last", 32'(s_last), 32'(e_last));
        chk("load_ready", 32'(load_ready), 32'(e_ready));
    endtask

    // Advance the model by one clock edge using the inputs held over the edge.
    task automatic model_step();
        logic acc;
        acc = load_valid && (!m_active || ((m_idx == W - 1) && shift_en));
        if (acc) exp_q.push_back(p_in);
        if (m_active) begin
            if (shift_en) begin
                if (m_idx < W - 1) m_idx++;
                else if (acc) begin m_word = p_in; m_idx = 0; end
                else m_active = 1'b0;
            end
        end else if (acc) begin
            m_active = 1'b1;
            m_word   = p_in;
            m_idx    = 0;
        end
    endtask

    // Right-shift SIPO fed from s_out, clocked on s_valid && shift_en.
    task automatic sipo_step(input logic cap, input logic b, input logic last);
        logic [W-1:0] word;
        if (cap) begin
            word = {b, sipo[W-1:1]};
            sipo = word;
            nbits++;
            bit_log.push_back(b);
            if (last) begin
                rx_log.push_back(word);
                chk("frame_len", 32'(nbits), 32'(W));
                if (exp_q.size() == 0) chk("rx_unexpected", 32'(word), 32'hFFFF_FFFF);
                else chk("rx_word", 32'(word), 32'(exp_q.pop_front()));
                nbits = 0;
            end
        end
    endtask

    // Put the head of the source queue on the bus, or idle with noise on p_in.
    task automatic offer();
        if (src_q.size() > 0) begin
            load_valid = 1'b1;
            p_in       = src_q[0];
        end else begin
            load_valid = 1'b0;
            p_in       = W'($urandom);
        end
    endtask

    // One clock cycle: inputs change 2 after posedge, checks at negedge.
    task automatic cycle(input logic en);
        logic acc, cap, b, last;
        shift_en = en;
        @(negedge clk);
        check_outputs();
        if (s_valid) vcnt++;
        acc  = load_valid && load_ready;
        cap  = s_valid && shift_en;
        b    = s_out;
        last = s_last;
        @(posedge clk);
        if (reset_n) begin
            sipo_step(cap, b, last);
            model_step();
        end
        #2;
        if (acc && src_q.size() > 0) void'(src_q.pop_front());
        offer();
    endtask

    task automatic clear_logs();
        bit_log.delete();
        rx_log.delete();
        vcnt = 0;
    endtask

    task automatic chk_bits(input string name, input logic [15:0] exp, input int n);
        chk({name, "_len"}, 32'(bit_log.size()), 32'(n));
        for (int i = 0; i < n && i < bit_log.size(); i++)
            chk(name, 32'(bit_log[i]), 32'(exp[n-1-i]));
    endtask

    task automatic send(input logic [W-1:0] w);
        src_q.push_back(w);
        offer();
    endtask

    // Drop reset between edges, check the line clears at once, then release.
    task automatic reset_mid_cycle();
        shift_en = 1'b1;
        #1;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        src_q.delete();
        model_clear();
        #1;
        chk("rst_s_out", 32'(s_out), 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_s_last", 32'(s_last), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        cycle(1'b1);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        p_in       = '0;
        shift_en   = 1'b0;
        model_clear();
        clear_logs();
        repeat (2) @(posedge clk);
        #2;
        cycle(1'b1);                 // outputs checked while held in reset
        reset_n = 1'b1;
        cycle(1'b1);

        // Basic frame: 1011 -> 1,1,0,1 then idle.
        clear_logs();
        send(4'b1011);
        repeat (6) cycle(1'b1);
        chk_bits("basic", 16'b1101, 4);
        chk("basic_vcnt", 32'(vcnt), 32'd4);

        // Back-to-back A then 5 with no idle gap.
        clear_logs();
        send(4'hA);
        send(4'h5);
        repeat (9) cycle(1'b1);
        chk_bits("b2b", 16'b0101_1010, 8);
        chk("b2b_vcnt", 32'(vcnt), 32'd8);
        repeat (2) cycle(1'b1);

        // Enable gating: 0110 under shift_en 1,0,0,1,1,0,1.
        clear_logs();
        send(4'b0110);
        cycle(1'b1);
        cycle(1'b1); cycle(1'b0); cycle(1'b0); cycle(1'b1);
        cycle(1'b1); cycle(1'b0); cycle(1'b1);
        chk_bits("gate", 16'b0110, 4);
        repeat (2) cycle(1'b1);

        // Reset after the second bit of F, then 3 transmits cleanly.
        send(4'hF);
        repeat (3) cycle(1'b1);
        reset_mid_cycle();
        clear_logs();
        send(4'h3);
        repeat (6) cycle(1'b1);
        chk_bits("post_rst", 16'b1100, 4);
        chk("post_rst_n", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) chk("post_rst_word", 32'(rx_log[0]), 32'h3);

        // Loopback through the SIPO: 9 then C.
        clear_logs();
        send(4'h9);
        send(4'hC);
        repeat (12) cycle(1'b1);
        chk("loop_n", 32'(rx_log.size()), 32'd2);
        if (rx_log.size() > 1) begin
            chk("loop_w0", 32'(rx_log[0]), 32'h9);
            chk("loop_w1", 32'(rx_log[1]), 32'hC);
        end

        // Handshake stall: 7 held while busy with no last-bit enable.
        clear_logs();
        send(4'h2);
        send(4'h7);
        cycle(1'b1);
        repeat (3) cycle(1'b1);      // reach last bit of 2
        repeat (5) cycle(1'b0);      // held on last bit, 7 must wait
        repeat (8) cycle(1'b1);
        chk("stall_n", 32'(rx_log.size()), 32'd2);
        if (rx_log.size() > 1) begin
            chk("stall_w0", 32'(rx_log[0]), 32'h2);
            chk("stall_w1", 32'(rx_log[1]), 32'h7);
        end

        // Randomized traffic with random bit-rate enable.
        for (int i = 0; i < 600; i++) begin
            if (src_q.size() < 2 && $urandom_range(0, 3) == 0) send(W'($urandom));
            if (i == 300) begin
                reset_mid_cycle();
            end else begin
                cycle($urandom_range(0, 9) < 7);
            end
        end
        repeat (20) cycle(1'b1);
        chk("drain_src", 32'(src_q.size()), 32'd0);
        chk("drain_exp", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_piso_rt_serializer
